// File: rtl/ramfifo_drain_arb_pkg.sv
// ============================================================================
// Module : ramfifo_drain_arb_pkg
// Brief  : Shared RAMFIFO defines: drain-arbiter state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ramfifo_drain_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/ramfifo_drain_arb_if.sv
// ============================================================================
// Module : ramfifo_drain_arb_if
// Brief  : Queue-status / read-strobe / output-qualifier bundle of the drain arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ramfifo_drain_arb_if #(
    parameter int NPORT     = 4,
    parameter int LOG_NPORT = 2
);
    logic                 enable;
    logic [NPORT-1:0]     empty;
    logic                 out_ready;
    logic [NPORT-1:0]     read;
    logic                 out_valid;
    logic [LOG_NPORT-1:0] out_sel;
    logic                 busy;

    modport master (
        input  enable, empty, out_ready,
        output read, out_valid, out_sel, busy
    );

    modport slave (
        output enable, empty, out_ready,
        input  read, out_valid, out_sel, busy
    );
endinterface

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module : rr_priority_pick
// Brief  : First asserted request searching upward from start, wrapping N-1 -> 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter int N     = 4,
    parameter int LOG_N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [LOG_N-1:0] start,
    output logic             found,
    output logic [LOG_N-1:0] idx
);

    logic [LOG_N-1:0] cand;

    // N is a power of two, so index arithmetic wraps naturally.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < N; i++) begin
            cand = start + LOG_N'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ramfifo_drain_arb.sv
// ============================================================================
// Module : ramfifo_drain_arb
// Brief  : Round-robin drain arbiter issuing quantum-limited read bursts to RAMFIFO queues.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ramfifo_drain_arb
    import ramfifo_drain_arb_pkg::*;
#(
    parameter int NPORT     = 4,
    parameter int LOG_NPORT = 2,
    parameter int QUANTUM   = 4
) (
    input  logic               clock,
    input  logic               reset,
    ramfifo_drain_arb_if.master bus
);

    localparam int             CW       = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(QUANTUM - 1);

    drain_state_e         state_q, state_d;
    logic [LOG_NPORT-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_NPORT-1:0] owner_q, owner_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic [LOG_NPORT-1:0] out_sel_q, out_sel_d;

    logic [NPORT-1:0]     w_req;
    logic                 w_found;
    logic [LOG_NPORT-1:0] w_pick;
    logic                 w_read_fire;

    assign w_req = ~bus.empty;

    rr_priority_pick #(
        .N     (NPORT),
        .LOG_N (LOG_NPORT)
    ) u_pick (
        .req   (w_req),
        .start (rr_ptr_q),
        .found (w_found),
        .idx   (w_pick)
    );

    // Reset suppresses the strobe in the same cycle so an abandoned grant never pops a word.
    assign w_read_fire = (state_q == GRANT) && bus.enable && bus.out_ready &&
                         !bus.empty[owner_q] && !reset;

    always_comb begin
        bus.read = '0;
        if (w_read_fire) begin
            bus.read[owner_q] = 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.busy      = (state_q == GRANT);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = w_read_fire;
        out_sel_d   = w_read_fire ? owner_q : out_sel_q;
        if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        owner_d = w_pick;
                        count_d = '0;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    if (w_read_fire) begin
                        count_d = count_q + CW'(1);
                        if (count_q == LAST_CNT) begin
                            state_d  = IDLE;
                            rr_ptr_d = owner_q + LOG_NPORT'(1);
                        end
                    end else if (bus.empty[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_q + LOG_NPORT'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ramfifo_drain_arb.sv
// ============================================================================
// Module : tb_ramfifo_drain_arb
// Brief  : Self-checking bench for ramfifo_drain_arb against a grant-session reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ramfifo_drain_arb;

    localparam int NPORT     = 4;
    localparam int LOG_NPORT = 2;
    localparam int QUANTUM   = 4;
    localparam int OW        = NPORT + LOG_NPORT + 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ramfifo_drain_arb_if #(.NPORT(NPORT), .LOG_NPORT(LOG_NPORT)) bus ();

    ramfifo_drain_arb #(
        .NPORT     (NPORT),
        .LOG_NPORT (LOG_NPORT),
        .QUANTUM   (QUANTUM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a grant session is "queue q, k reads done so far".
    bit m_grant = 1'b0;
    int m_owner = 0;
    int m_done  = 0;
    int m_ptr   = 0;
    bit m_valid = 1'b0;
    int m_sel   = 0;

    logic [OW-1:0]    obs, exp;
    logic [NPORT-1:0] e_read;
    bit               safe;

    task automatic step(input bit rst, input bit en, input logic [NPORT-1:0] emp, input bit rdy);
        @(negedge clock);
        reset         = rst;
        bus.enable    = en;
        bus.empty     = emp;
        bus.out_ready = rdy;
        #1;
        e_read = '0;
        if (m_grant && en && rdy && !emp[m_owner] && !rst) e_read[m_owner] = 1'b1;
        exp  = {e_read, m_valid, LOG_NPORT'(m_sel), m_grant};
        obs  = {bus.read, bus.out_valid, bus.out_sel, bus.busy};
        safe = $onehot0(bus.read) && ((bus.read & emp) == '0);
        @(posedge clock);
        if (rst) begin
            m_grant = 1'b0; m_owner = 0; m_done = 0; m_ptr = 0; m_valid = 1'b0; m_sel = 0;
        end else if (!en) begin
            m_valid = 1'b0;
        end else if (!m_grant) begin
            m_valid = 1'b0;
            for (int k = 0; k < NPORT; k++) begin
                int q;
                q = (m_ptr + k) % NPORT;
                if (!emp[q]) begin
                    m_grant = 1'b1; m_owner = q; m_done = 0;
                    break;
                end
            end
        end else if (e_read != '0) begin
            m_valid = 1'b1;
            m_sel   = m_owner;
            m_done++;
            if (m_done == QUANTUM) begin
                m_grant = 1'b0; m_ptr = (m_owner + 1) % NPORT;
            end
        end else begin
            m_valid = 1'b0;
            if (emp[m_owner]) begin
                m_grant = 1'b0; m_ptr = (m_owner + 1) % NPORT;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'b0000, 1'b1);
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b required %b", obs, {OW{1'b0}});
            end
        end
    endtask

    task automatic test_all_empty();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 4'b1111, 1'b1);
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL all_empty cyc %0d: got %b required %b", i, obs, {OW{1'b0}});
            end
        end
    endtask

    task automatic test_single_queue();
        int reads = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 4'b1101, 1'b1);
            if (bus.read == 4'b0010) reads++;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_queue cyc %0d: got %b required %b", i, obs, exp);
            end
        end
        // idle, 4 reads, idle, 4 reads, idle, 4 reads
        n_checks++;
        if (reads != 12) begin
            n_fail++;
            $display("FAIL single_queue_reads: got %0d required 12", reads);
        end
    endtask

    task automatic test_two_queues();
        int order[$];
        int runs[$];
        int exp_order[4] = '{0, 2, 0, 2};
        logic [NPORT-1:0] prev = '0;
        step(1'b1, 1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 4'b1010, 1'b1);
            if (bus.read != '0) begin
                if (prev == '0) begin
                    order.push_back(bus.read == 4'b0001 ? 0 : (bus.read == 4'b0100 ? 2 : 9));
                    runs.push_back(0);
                end
                runs[runs.size()-1]++;
            end
            prev = bus.read;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL two_queues cyc %0d: got %b required %b", i, obs, exp);
            end
        end
        n_checks++;
        if (order.size() != 4) begin
            n_fail++;
            $display("FAIL two_queues_grants: got %0d grants required 4", order.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                n_checks++;
                if (order[g] != exp_order[g] || runs[g] != QUANTUM) begin
                    n_fail++;
                    $display("FAIL two_queues_grant %0d: got q%0d x%0d required q%0d x%0d",
                             g, order[g], runs[g], exp_order[g], QUANTUM);
                end
            end
        end
    endtask

    task automatic test_early_empty();
        int guard = 0;
        step(1'b1, 1'b1, 4'b1111, 1'b1);
        while (!(m_grant && m_done == 2) && guard < 20) begin
            step(1'b0, 1'b1, 4'b0111, 1'b1);
            guard++;
        end
        n_checks++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL early_empty_timeout: got %0d cycles required <20", guard);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 4'b1111, 1'b1);
            n_checks++;
            if (obs !== exp || bus.read !== 4'b0000) begin
                n_fail++;
                $display("FAIL early_empty_exit %0d: got %b required %b", i, obs, exp);
            end
        end
        // rr_ptr now 0: with queues 0 and 3 pending, queue 0 wins
        step(1'b0, 1'b1, 4'b0110, 1'b1);
        step(1'b0, 1'b1, 4'b0110, 1'b1);
        n_checks++;
        if (bus.read !== 4'b0001 || obs !== exp) begin
            n_fail++;
            $display("FAIL early_empty_next: got read %b required 0001", bus.read);
        end
    endtask

    task automatic test_stall();
        int guard = 0;
        int reads = 0;
        step(1'b1, 1'b1, 4'b1111, 1'b1);
        while (!(m_grant && m_done == 2) && guard < 20) begin
            step(1'b0, 1'b1, 4'b1110, 1'b1);
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'b1110, 1'b0);
            n_checks++;
            if (bus.read !== 4'b0000 || bus.busy !== 1'b1 || obs !== exp) begin
                n_fail++;
                $display("FAIL stall cyc %0d: got %b required %b", i, obs, exp);
            end
        end
        guard = 0;
        while (m_grant && guard < 10) begin
            step(1'b0, 1'b1, 4'b1110, 1'b1);
            if (bus.read == 4'b0001) reads++;
            guard++;
        end
        n_checks++;
        if (reads != 2) begin
            n_fail++;
            $display("FAIL stall_resume_reads: got %0d required 2", reads);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        step(1'b1, 1'b1, 4'b1111, 1'b1);
        while (!(m_grant && m_done == 1) && guard < 20) begin
            step(1'b0, 1'b1, 4'b1110, 1'b1);
            guard++;
        end
        step(1'b1, 1'b1, 4'b1110, 1'b1);
        n_checks++;
        if (bus.read !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_read: got %b required 0000", bus.read);
        end
        step(1'b0, 1'b1, 4'b1111, 1'b1);
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b required %b", obs, {OW{1'b0}});
        end
        step(1'b0, 1'b1, 4'b0110, 1'b1);
        step(1'b0, 1'b1, 4'b0110, 1'b1);
        n_checks++;
        if (bus.read !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid_ptr: got read %b required 0001", bus.read);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit rst, en, rdy;
            logic [NPORT-1:0] emp;
            rst = ($urandom_range(99) < 2);
            en  = ($urandom_range(99) < 85);
            rdy = ($urandom_range(99) < 75);
            emp = NPORT'($urandom) | NPORT'($urandom);
            step(rst, en, emp, rdy);
            n_checks++;
            if (obs !== exp || !safe) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b required %b safe=%0d", i, obs, exp, safe);
            end
        end
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.empty     = '1;
        bus.out_ready = 1'b0;
        test_reset();
        test_all_empty();
        test_single_queue();
        test_two_queues();
        test_early_empty();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ramfifo_drain_arb.md
RAMFIFO_DRAIN_ARB -- requirements
Module: ramfifo_drain_arb

Interface
REQ-001 Parameter NPORT, default 4; number of RAMFIFO queues drained (power of two, 2..16).
REQ-002 Parameter LOG_NPORT, default 2; log2(NPORT), width of queue index.
REQ-003 Parameter QUANTUM, default 4; max consecutive reads granted to one queue per grant (1..15).
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  global advance; low freezes all state and suppresses reads.
REQ-007 empty  input  NPORT  per-queue empty flag from each RAMFIFO controller.
REQ-008 out_ready  input  1  downstream accepts a word in the cycle after a read strobe.
REQ-009 read  output  NPORT  one-hot (or zero) read strobe to each RAMFIFO controller.
REQ-010 out_valid  output  1  RAM read data valid this cycle (one cycle after read).
REQ-011 out_sel  output  LOG_NPORT  queue index of the word qualified by out_valid; drives the data mux.
REQ-012 busy  output  1  high while in GRANT state.

Function
REQ-013 State machine SHALL have two states: IDLE, GRANT.
REQ-014 IDLE: if enable and any empty bit low, owner SHALL be set to first non-empty queue searching upward from rr_ptr (wrapping NPORT-1 -> 0), count cleared, next state GRANT; no read issued in IDLE.
REQ-015 GRANT: read[owner] SHALL be asserted combinationally iff enable & out_ready & ~empty[owner]; all other read bits zero.
REQ-016 Each asserted read SHALL increment count (width ceil(log2(QUANTUM+1)) bits, no wrap beyond QUANTUM).
REQ-017 GRANT -> IDLE SHALL occur when a read is issued with count == QUANTUM-1, or when enable is high and empty[owner] is high; on exit rr_ptr SHALL become owner+1 modulo NPORT.
REQ-018 GRANT with enable high, out_ready low and empty[owner] low SHALL hold state, owner and count (stall, no exit).
REQ-019 out_valid SHALL register |read; out_sel SHALL register owner when a read is issued, else hold its value.
REQ-020 Latency: read at cycle N -> out_valid and out_sel at cycle N+1, matching 1-cycle RAM read latency.
REQ-021 At most one read bit SHALL be high in any cycle; read SHALL never assert to a queue whose empty bit is high.
REQ-022 enable low SHALL hold state, owner, count, rr_ptr, out_sel; read zero; out_valid zero next cycle.
REQ-023 Each grant costs one IDLE bubble cycle; back-to-back grants to the same queue SHALL be allowed only when no other queue is non-empty.

Reset
REQ-024 reset SHALL force: state IDLE, rr_ptr 0, owner 0, count 0, out_valid 0, out_sel 0, busy 0, read 0.
REQ-025 reset asserted mid-GRANT SHALL abandon the grant with no read in that cycle; reset has priority over enable.

Structure
REQ-026 State encodings (IDLE=0, GRANT=1) SHALL be localparams in the shared RAMFIFO defines package used by all RAMFIFO blocks.
REQ-027 Rotating-priority selection SHALL be one sub-module rr_priority_pick (inputs req vector and start index; outputs found flag and index).
REQ-028 Block SHALL be pure control; data mux lives outside, driven by out_sel.

Verification
REQ-029 empty=4'b1111 for 10 cycles after reset -> read=0, busy=0, out_valid=0 throughout.
REQ-030 empty=4'b1101 held, out_ready=1, QUANTUM=4 -> reads to queue 1 on 4 consecutive cycles, IDLE bubble, repeat; out_sel=1 with out_valid one cycle after each read.
REQ-031 queues 0 and 2 non-empty, out_ready=1 -> grant order 0,2,0,2; each 4 reads; rr_ptr 1 after first grant.
REQ-032 queue 3 granted, empty[3] rises after 2 reads -> exit to IDLE, rr_ptr=0, no read to 3 while empty[3]=1.
REQ-033 out_ready low 3 cycles mid-grant at count=2 -> read=0, count holds 2, resumes 2 more reads then exit.
REQ-034 reset pulsed mid-GRANT at count=1 -> next cycle state IDLE, read=0, out_valid=0, rr_ptr=0.
